// File: rtl/vsa_ifetch_buffer.sv
// Two-entry instruction fetch buffer sitting between the processor pc and a
// slow instruction ROM. A hit returns the buffered word combinationally. A
// miss issues a demand fetch. A hit can also trigger a sequential prefetch of
// pc+2. Only one ROM transaction is ever in flight.
module vsa_ifetch_buffer #(
    parameter int PREFETCH_EN = 1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [4:0]  pc,
    input  logic        flush,
    output logic [11:0] instruction,
    output logic        inst_valid,
    output logic        mem_req,
    output logic [4:0]  mem_addr,
    input  logic        mem_ack,
    input  logic [11:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEMAND   = 2'd1,
        PREFETCH = 2'd2
    } fetchState;

    fetchState   stateReg, stateNext;

    logic [1:0]  validReg, validNext;
    logic [4:0]  tagReg  [0:1];
    logic [4:0]  tagNext [0:1];
    logic [11:0] dataReg [0:1];
    logic [11:0] dataNext[0:1];
    logic        ptrReg, ptrNext;
    logic        memReqReg, memReqNext;
    logic [4:0]  memAddrReg, memAddrNext;
    // Set when a flush lands while a transaction is in flight.
    // The returning data is then stale and must not be written.
    logic        discardReg, discardNext;
    // Low for the first edge after reset so no request goes out on that edge.
    logic        readyReg;

    logic [4:0]  pcPlus2;
    logic [1:0]  hitVec;
    logic [1:0]  nextHitVec;
    logic        victim;

    // Sequential address wraps naturally in 5 bits (30 -> 0, 31 -> 1)
    assign pcPlus2 = pc + 5'd2;

    // Per-entry tag compare against pc and against the prefetch candidate
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : gCompare
            assign hitVec[gi]     = validReg[gi] && (tagReg[gi] == pc);
            assign nextHitVec[gi] = validReg[gi] && (tagReg[gi] == pcPlus2);
        end
    endgenerate

    // Read port: return the hitting entry's word, or zero on a miss
    always_comb begin
        instruction = 12'h000;
        if (hitVec[0]) begin
            instruction = dataReg[0];
        end else if (hitVec[1]) begin
            instruction = dataReg[1];
        end
    end

    assign inst_valid = |hitVec;
    assign mem_req    = memReqReg;
    assign mem_addr   = memAddrReg;

    // Victim choice: fill a free slot first. Otherwise follow the pointer,
    // but never evict the word the processor is currently executing.
    always_comb begin
        victim = 1'b0;
        if (!validReg[0]) begin
            victim = 1'b0;
        end else if (!validReg[1]) begin
            victim = 1'b1;
        end else if (tagReg[ptrReg] == pc) begin
            victim = ~ptrReg;
        end else begin
            victim = ptrReg;
        end
    end

    // Next-state and fill logic for the fetch FSM
    always_comb begin
        stateNext   = stateReg;
        validNext   = validReg;
        tagNext     = tagReg;
        dataNext    = dataReg;
        ptrNext     = ptrReg;
        memReqNext  = memReqReg;
        memAddrNext = memAddrReg;
        discardNext = discardReg;

        case (stateReg)
            IDLE: begin
                if (flush) begin
                    validNext = 2'b00;
                end else if (readyReg) begin
                    if (!inst_valid) begin
                        stateNext   = DEMAND;
                        memReqNext  = 1'b1;
                        memAddrNext = pc;
                    end else if ((PREFETCH_EN != 0) && !(|nextHitVec)) begin
                        stateNext   = PREFETCH;
                        memReqNext  = 1'b1;
                        memAddrNext = pcPlus2;
                    end
                end
            end

            DEMAND, PREFETCH: begin
                if (mem_ack) begin
                    if (!flush && !discardReg) begin
                        validNext[victim] = 1'b1;
                        tagNext[victim]   = memAddrReg;
                        dataNext[victim]  = mem_rdata;
                        ptrNext           = ~victim;
                    end
                    memReqNext  = 1'b0;
                    discardNext = 1'b0;
                    stateNext   = IDLE;
                end else if (flush) begin
                    discardNext = 1'b1;
                end
                if (flush) begin
                    validNext = 2'b00;
                end
            end

            default: begin
                stateNext  = IDLE;
                memReqNext = 1'b0;
            end
        endcase
    end

    // State register. Reset abandons any transaction immediately.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stateReg   <= IDLE;
            validReg   <= 2'b00;
            tagReg[0]  <= 5'd0;
            tagReg[1]  <= 5'd0;
            dataReg[0] <= 12'h000;
            dataReg[1] <= 12'h000;
            ptrReg     <= 1'b0;
            memReqReg  <= 1'b0;
            memAddrReg <= 5'd0;
            discardReg <= 1'b0;
            readyReg   <= 1'b0;
        end else begin
            stateReg   <= stateNext;
            validReg   <= validNext;
            tagReg     <= tagNext;
            dataReg    <= dataNext;
            ptrReg     <= ptrNext;
            memReqReg  <= memReqNext;
            memAddrReg <= memAddrNext;
            discardReg <= discardNext;
            readyReg   <= 1'b1;
        end
    end

endmodule

// File: tb/tb_vsa_ifetch_buffer.sv
// Bench for vsa_ifetch_buffer. It runs directed scenarios and then random
// traffic. The design is compared each cycle against a transaction-level
// model of the buffer.
module tb_vsa_ifetch_buffer;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [4:0]  pc;
    logic        flush;
    logic [11:0] instruction;
    logic        inst_valid;
    logic        mem_req;
    logic [4:0]  mem_addr;
    logic        mem_ack;
    logic [11:0] mem_rdata;

    always #5 clock = ~clock;

    vsa_ifetch_buffer #(.PREFETCH_EN(1)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .pc         (pc),
        .flush      (flush),
        .instruction(instruction),
        .inst_valid (inst_valid),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata)
    );

    int compared   = 0;
    int mismatched = 0;

    logic [11:0] rom [32];

    // ---------------- reference model ----------------
    // Buffer contents, the one outstanding request, and whether it is stale
    bit          mValid [2];
    logic [4:0]  mTag   [2];
    logic [11:0] mData  [2];
    int          mPtr;
    bit          mBusy;
    logic [4:0]  mAddr;
    bit          mStale;
    bit          mReady;

    function automatic int mFind(input logic [4:0] a);
        for (int i = 0; i < 2; i++) begin
            if (mValid[i] && mTag[i] == a) return i;
        end
        return -1;
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 2; i++) begin
            mValid[i] = 0;
            mTag[i]   = 5'd0;
            mData[i]  = 12'h000;
        end
        mPtr   = 0;
        mBusy  = 0;
        mAddr  = 5'd0;
        mStale = 0;
        mReady = 0;
    endtask

    task automatic modelInvalidate();
        mValid[0] = 0;
        mValid[1] = 0;
    endtask

    // Apply one clock edge worth of behaviour to the model
    task automatic modelAdvance(input logic [4:0] p, input logic f,
                                input logic a, input logic [11:0] d);
        int v;
        logic [4:0] seqAddr;
        seqAddr = 5'((int'(p) + 2) % 32);
        if (!mBusy) begin
            // stray acks are irrelevant here
            if (f) begin
                modelInvalidate();
            end else if (mReady) begin
                if (mFind(p) < 0) begin
                    mBusy = 1;
                    mAddr = p;
                end else if (mFind(seqAddr) < 0) begin
                    mBusy = 1;
                    mAddr = seqAddr;
                end
            end
        end else if (a) begin
            if (!f && !mStale) begin
                if (!mValid[0])            v = 0;
                else if (!mValid[1])       v = 1;
                else if (mTag[mPtr] == p)  v = 1 - mPtr;
                else                       v = mPtr;
                mValid[v] = 1;
                mTag[v]   = mAddr;
                mData[v]  = d;
                mPtr      = 1 - v;
            end
            mBusy  = 0;
            mStale = 0;
            if (f) modelInvalidate();
        end else if (f) begin
            modelInvalidate();
            mStale = 1;
        end
        mReady = 1;
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutputs(input string where);
        int idx;
        logic [11:0] expInstr;
        idx = mFind(pc);
        expInstr = (idx >= 0) ? mData[idx] : 12'h000;
        chk({where, ".inst_valid"}, 32'(inst_valid), 32'(idx >= 0));
        chk({where, ".instruction"}, 32'(instruction), 32'(expInstr));
        chk({where, ".mem_req"}, 32'(mem_req), 32'(mBusy));
        chk({where, ".mem_addr"}, 32'(mem_addr), 32'(mAddr));
    endtask

    // One clock cycle with the given inputs, then compare all outputs
    task automatic step(input logic [4:0] p, input logic f,
                        input logic a, input logic [11:0] d);
        pc        = p;
        flush     = f;
        mem_ack   = a;
        mem_rdata = d;
        modelAdvance(p, f, a, d);
        @(posedge clock);
        #1;
        mem_ack = 1'b0;
        flush   = 1'b0;
        checkOutputs("cyc");
        $display("cycle pc=%0d flush=%0d ack=%0d -> req=%0d addr=%0d valid=%0d instr=%03h",
                 p, f, a, mem_req, mem_addr, inst_valid, instruction);
    endtask

    task automatic ackNow(input logic [4:0] p);
        step(p, 1'b0, 1'b1, rom[mem_addr]);
    endtask

    task automatic runUntilReq(input logic [4:0] p, output int n);
        n = 0;
        while (!mem_req && n < 8) begin
            step(p, 1'b0, 1'b0, 12'h000);
            n++;
        end
        if (!mem_req) chk("wait_req_timeout", 32'(mem_req), 32'd1);
    endtask

    task automatic doReset();
        reset_n   = 1'b0;
        mem_ack   = 1'b0;
        flush     = 1'b0;
        mem_rdata = 12'h000;
        modelReset();
        #1;
        checkOutputs("reset");
        repeat (2) @(posedge clock);
        #1;
        checkOutputs("in_reset");
        reset_n = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        logic [4:0] curPc;
        logic [11:0] d;
        bit f, a;

        for (int i = 0; i < 32; i++) rom[i] = 12'($urandom);
        rom[0] = 12'h6A5;
        pc = 5'd0;
        reset_n = 1'b0;
        flush = 1'b0;
        mem_ack = 1'b0;
        mem_rdata = 12'h000;
        @(posedge clock);
        #1;

        // Cold miss: first request on second edge, fill visible the cycle after ack
        doReset();
        runUntilReq(5'd0, n);
        chk("cold_latency", 32'(n), 32'd2);
        chk("cold_addr", 32'(mem_addr), 32'd0);
        step(5'd0, 1'b0, 1'b0, 12'h000);
        ackNow(5'd0);
        chk("cold_valid", 32'(inst_valid), 32'd1);
        chk("cold_instr", 32'(instruction), 32'h6A5);
        step(5'd0, 1'b0, 1'b0, 12'h000);
        chk("cold_pf_req", 32'(mem_req), 32'd1);
        chk("cold_pf_addr", 32'(mem_addr), 32'd2);

        // Wrap-around prefetch from pc=30 to address 0
        doReset();
        runUntilReq(5'd30, n);
        ackNow(5'd30);
        runUntilReq(5'd30, n);
        chk("wrap_addr", 32'(mem_addr), 32'd0);
        step(5'd30, 1'b0, 1'b0, 12'h000);
        step(5'd0, 1'b0, 1'b1, rom[mem_addr]);
        chk("wrap_hit", 32'(inst_valid), 32'd1);
        chk("wrap_noreq", 32'(mem_req), 32'd0);

        // Replacement: pointer lands on the entry holding pc, so the other one goes
        doReset();
        runUntilReq(5'd2, n);
        ackNow(5'd0);                 // tag 2 -> entry 0, pc moved to 0
        runUntilReq(5'd0, n);
        ackNow(5'd0);                 // tag 0 -> entry 1, pointer back to entry 0
        runUntilReq(5'd2, n);
        chk("repl_pf_addr", 32'(mem_addr), 32'd4);
        ackNow(5'd2);
        chk("repl_keep2", 32'(inst_valid), 32'd1);
        pc = 5'd0; #1;
        chk("repl_evict0", 32'(inst_valid), 32'd0);
        pc = 5'd4; #1;
        chk("repl_have4", 32'(inst_valid), 32'd1);
        pc = 5'd2; #1;

        // pc change mid-transaction does not redirect the fill
        doReset();
        runUntilReq(5'd4, n);
        step(5'd8, 1'b0, 1'b0, 12'h000);
        ackNow(5'd8);
        chk("pcchg_miss8", 32'(inst_valid), 32'd0);
        pc = 5'd4; #1;
        chk("pcchg_fill4", 32'(inst_valid), 32'd1);
        step(5'd8, 1'b0, 1'b0, 12'h000);
        chk("pcchg_req", 32'(mem_req), 32'd1);
        chk("pcchg_addr", 32'(mem_addr), 32'd8);

        // Flush one cycle before the ack discards the fill
        doReset();
        runUntilReq(5'd6, n);
        step(5'd6, 1'b1, 1'b0, 12'h000);
        ackNow(5'd6);
        chk("flush_valid", 32'(inst_valid), 32'd0);
        step(5'd6, 1'b0, 1'b0, 12'h000);
        chk("flush_redemand", 32'(mem_req), 32'd1);
        chk("flush_addr", 32'(mem_addr), 32'd6);

        // Reset mid-transaction, then a stray ack
        doReset();
        runUntilReq(5'd10, n);
        reset_n = 1'b0;
        #1;
        chk("rstmid_req", 32'(mem_req), 32'd0);
        doReset();
        step(5'd10, 1'b0, 1'b1, 12'hBAD);
        chk("rstmid_stray", 32'(inst_valid), 32'd0);
        step(5'd10, 1'b0, 1'b0, 12'h000);

        // Random traffic
        curPc = 5'd10;
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 9))
                0, 1:    curPc = 5'($urandom_range(0, 31));
                2:       curPc = curPc + 5'd2;
                default: ;
            endcase
            f = ($urandom_range(0, 99) < 3);
            if (mBusy) begin
                a = ($urandom_range(0, 99) < 35);
                d = rom[mem_addr];
            end else begin
                a = ($urandom_range(0, 99) < 8);
                d = 12'($urandom);
            end
            step(curPc, f, a, d);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/vsa_ifetch_buffer.md
VSA_IFETCH_BUFFER -- requirements
Module: vsa_ifetch_buffer

Interface
REQ-001 The block SHALL have one parameter: PREFETCH_EN, default 1, meaning 1 enables sequential prefetch of pc+2 and 0 gives demand fetch only.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-003 The block SHALL have the port `clock`: input, 1 bit, master clock, all state updates on its rising edge.
REQ-004 The block SHALL have the port `reset_n`: input, 1 bit, asynchronous active-low reset.
REQ-005 The block SHALL have the port `pc`: input, 5 bits, instruction address from the processor.
REQ-006 The block SHALL have the port `flush`: input, 1 bit, invalidate the buffer.
REQ-007 The block SHALL have the port `instruction`: output, 12 bits, instruction word for `pc`.
REQ-008 The block SHALL have the port `inst_valid`: output, 1 bit, `instruction` holds the word at `pc`.
REQ-009 The block SHALL have the port `mem_req`: output, 1 bit, instruction ROM request, registered.
REQ-010 The block SHALL have the port `mem_addr`: output, 5 bits, instruction ROM address, registered.
REQ-011 The block SHALL have the port `mem_ack`: input, 1 bit, ROM data valid, one-cycle pulse.
REQ-012 The block SHALL have the port `mem_rdata`: input, 12 bits, ROM read data, valid when `mem_ack`=1.

Function
REQ-013 The block SHALL hold two buffer entries; each entry has a valid bit, a 5-bit tag and 12-bit data.
REQ-014 The block SHALL define a hit as: some entry has valid=1 and tag==pc.
- On a hit: `inst_valid`=1 and `instruction`=that entry's data, combinationally from registered state.
- On a miss: `inst_valid`=0 and `instruction`=12'h000.
REQ-015 The FSM SHALL have the states IDLE, DEMAND and PREFETCH, with one outstanding ROM transaction at most.
REQ-016 In IDLE, on a miss with `flush`=0, the next state SHALL be DEMAND, with mem_req<=1 and mem_addr<=pc.
REQ-017 In IDLE, on a hit with PREFETCH_EN=1, `flush`=0 and no valid entry tagged (pc+2) mod 32, the next state SHALL be PREFETCH, with mem_req<=1 and mem_addr<=(pc+2) mod 32.
- Wrap-around: pc=30 prefetches address 0; pc=31 prefetches address 1.
REQ-018 In DEMAND or PREFETCH, `mem_req` and `mem_addr` SHALL be held stable until a cycle with `mem_ack`=1.
REQ-019 In that ack cycle, the block SHALL write mem_rdata and the tag mem_addr into the victim entry, set its valid bit, set mem_req<=0 and return to IDLE.
REQ-020 A `pc` change during DEMAND or PREFETCH SHALL NOT abort or alter the transaction.
- IDLE re-evaluates `pc` on the cycle after the fill.
REQ-021 Victim selection SHALL follow these rules:
- If an entry is invalid, the lowest-index invalid entry is the victim.
- Otherwise the entry indicated by the 1-bit replacement pointer is the victim.
- If that entry's tag==pc, the other entry is the victim instead.
- The pointer toggles to the entry not written, after each fill.
REQ-022 `mem_ack` while `mem_req`=0 SHALL be ignored, with no state change.
REQ-023 `flush`=1 SHALL clear both valid bits at the next edge.
- If a transaction is outstanding, the fill is discarded and not written.
- The request still completes on its ack, then the FSM returns to IDLE.
REQ-024 When `flush` and `mem_ack` are both 1 in the same cycle, the data SHALL be discarded, the valid bits cleared, mem_req<=0 and the next state IDLE.
REQ-025 IDLE SHALL NOT issue a request in a cycle where `flush`=1.
REQ-026 Latency: with `pc` stable, a miss in cycle t SHALL raise `mem_req` in cycle t+1, and an ack in cycle k SHALL raise `inst_valid` in cycle k+1.
REQ-027 Tag compare and the pc+2 computation SHALL use 5-bit arithmetic modulo 32, with no carry out.

Reset
REQ-028 While reset_n=0, the block SHALL hold: both entries invalid, tags and data 0, replacement pointer 0, FSM in IDLE, mem_req=0, mem_addr=0, inst_valid=0, instruction=12'h000.
REQ-029 Reset asserted mid-transaction SHALL abandon the transaction immediately; a later `mem_ack` with mem_req=0 is ignored (REQ-022).
REQ-030 The first request SHALL be issued no earlier than the second rising edge after reset_n deasserts.

Verification
REQ-031 The bench SHALL cover these directed scenarios:
- Cold miss: reset, pc=0, ROM ack after 2 cycles with rdata=12'h6A5 -> mem_req=1, mem_addr=0 at cycle 1; inst_valid=1, instruction=12'h6A5 the cycle after ack; then prefetch request with mem_addr=2.
- Wrap-around: entry tag 30 valid, pc=30, PREFETCH_EN=1 -> mem_addr=0; after ack, pc=0 hits with no new request.
- Replacement: entries tag 0 and tag 2, pointer at the entry holding pc; pc=2, miss on 4 -> the tag-0 entry is replaced; the tag-2 entry is kept.
- pc change mid-transaction: DEMAND for pc=4, pc changes to 8 before ack -> tag 4 is filled; next cycle a DEMAND for 8 is issued.
- Flush during fill: flush=1 one cycle before ack -> no entry valid after ack; inst_valid=0; a new DEMAND for the current pc follows.
- Reset mid-transaction: reset_n=0 while mem_req=1 -> mem_req=0 immediately; a stray mem_ack after reset causes no fill.
